// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the integer register file with busy scoreboard.
package regfile_scoreboard_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int ZERO_IDX       = 0;

    // LSB of lane idx inside a flat vector built from w-bit lanes.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array mux, hardwired-zero force and writeback bypass.
module rf_read_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]             raddr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  rf,
    input  logic [DEPTH-1:0]                  busy,
    input  logic                              wen,
    input  logic [ADDR_WIDTH-1:0]             waddr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              rbusy
);

    logic is_zero;
    logic hit_wb;

    assign is_zero = (ZERO_REG != 0) && (raddr == ADDR_WIDTH'(ZERO_IDX));
    assign hit_wb  = (BYPASS != 0) && wen && (waddr == raddr);

    // Zero force is applied last so a dropped r0 write can never leak through the bypass.
    always_comb begin
        rdata = rf[raddr];
        rbusy = busy[raddr];
        if (hit_wb) begin
            rdata = wdata;
            rbusy = 1'b0;
        end
        if (is_zero) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD bypassed read ports and a per-register busy scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wen,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [NREAD*ADDR_WIDTH-1:0]    raddr,
    output logic [NREAD*DATA_WIDTH-1:0]    rdata,
    output logic [NREAD-1:0]               rbusy,
    input  logic                           iss_en,
    input  logic [ADDR_WIDTH-1:0]          iss_rd,
    input  logic                           flush,
    output logic [ADDR_WIDTH:0]            busy_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] rf;
    logic [DEPTH-1:0]                 busy;
    logic [DEPTH-1:0]                 busy_nxt;
    logic [ADDR_WIDTH:0]              cnt_nxt;
    logic                             wr_ok;

    assign wr_ok = wen && !((ZERO_REG != 0) && (waddr == ADDR_WIDTH'(ZERO_IDX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf <= '0;
        end else if (wr_ok) begin
            rf[waddr] <= wdata;
        end
    end

    // Issue beats writeback on the same register: the new producer supersedes the old one.
    always_comb begin
        busy_nxt = '0;
        cnt_nxt  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            logic set_r;
            logic clr_r;
            set_r = iss_en && (iss_rd == ADDR_WIDTH'(r)) &&
                    !((ZERO_REG != 0) && (r == ZERO_IDX));
            clr_r = wen && (waddr == ADDR_WIDTH'(r));
            busy_nxt[r] = !flush && (set_r || (busy[r] && !clr_r));
            cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    generate
        for (genvar i = 0; i < NREAD; i++) begin : g_rd
            rf_read_port #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .ZERO_REG   (ZERO_REG),
                .BYPASS     (BYPASS),
                .DEPTH      (DEPTH)
            ) u_port (
                .raddr (raddr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]),
                .rf    (rf),
                .busy  (busy),
                .wen   (wen),
                .waddr (waddr),
                .wdata (wdata),
                .rdata (rdata[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
                .rbusy (rbusy[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: expected values queued at drive time, popped and asserted at sample time.
module tb_regfile_scoreboard;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              iss_en;
    logic [AW-1:0]     iss_rd;
    logic              flush;
    logic [AW:0]       busy_cnt;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR),
                         .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .iss_en(iss_en),
        .iss_rd(iss_rd), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic idle();
        wen = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b1; waddr = 5'd3; wdata = '1;
        iss_en = 1'b1; iss_rd = 5'd3; flush = 1'b0; rd(5'd3, 5'd4);
        repeat (3) tick();
        idle();
        rst_n = 1'b1;
        #1;
        push("rst_rdata0", 64'h0);  chk(rdata[DW-1:0]);
        push("rst_rbusy", 64'h0);   chk(64'(rbusy));
        push("rst_cnt", 64'h0);     chk(64'(busy_cnt));

        // hardwired zero register
        wen = 1'b1; waddr = 5'd0; wdata = 64'hDEADBEEF; rd(5'd0, 5'd0);
        #1;
        push("zero_bypass", 64'h0); chk(rdata[DW-1:0]);
        tick(); idle(); #1;
        push("zero_rd0", 64'h0);    chk(rdata[DW-1:0]);
        push("zero_rd1", 64'h0);    chk(rdata[2*DW-1:DW]);
        push("zero_busy", 64'h0);   chk(64'(rbusy));
        iss_en = 1'b1; iss_rd = 5'd0;
        tick(); idle(); #1;
        push("zero_iss_cnt", 64'h0); chk(64'(busy_cnt));

        // write, bypass, then registered value
        wen = 1'b1; waddr = 5'd5; wdata = 64'h1234; rd(5'd5, 5'd6);
        #1;
        push("byp_rd0", 64'h1234);  chk(rdata[DW-1:0]);
        push("byp_rd1", 64'h0);     chk(rdata[2*DW-1:DW]);
        tick(); idle(); #1;
        push("wr_rd0", 64'h1234);   chk(rdata[DW-1:0]);

        // issue / writeback lifecycle on r7
        iss_en = 1'b1; iss_rd = 5'd7;
        tick(); idle(); rd(5'd7, 5'd5); #1;
        push("sb_busy", 64'h1);     chk(64'(rbusy));
        push("sb_cnt1", 64'h1);     chk(64'(busy_cnt));
        tick(); tick();
        wen = 1'b1; waddr = 5'd7; wdata = 64'h77; #1;
        push("sb_byp_busy", 64'h0); chk(64'(rbusy));
        push("sb_byp_data", 64'h77); chk(rdata[DW-1:0]);
        push("sb_cnt_hold", 64'h1); chk(64'(busy_cnt));
        tick(); idle(); #1;
        push("sb_clr_busy", 64'h0); chk(64'(rbusy));
        push("sb_clr_cnt", 64'h0);  chk(64'(busy_cnt));
        push("sb_data", 64'h77);    chk(rdata[DW-1:0]);

        // same-cycle set and clear on r9
        iss_en = 1'b1; iss_rd = 5'd9;
        tick(); idle();
        iss_en = 1'b1; iss_rd = 5'd9; wen = 1'b1; waddr = 5'd9; wdata = 64'h99;
        tick(); idle(); rd(5'd9, 5'd0); #1;
        push("sc_data", 64'h99);    chk(rdata[DW-1:0]);
        push("sc_busy", 64'h1);     chk(64'(rbusy));
        push("sc_cnt", 64'h1);      chk(64'(busy_cnt));
        wen = 1'b1; waddr = 5'd9; wdata = 64'h9A;
        tick(); idle(); #1;
        push("sc_clr_cnt", 64'h0);  chk(64'(busy_cnt));

        // flush drops issue and clears everything, data write still lands
        for (int r = 1; r <= 3; r++) begin
            iss_en = 1'b1; iss_rd = AW'(r);
            tick();
        end
        idle(); rd(5'd2, 5'd3); #1;
        push("fl_cnt3", 64'h3);     chk(64'(busy_cnt));
        push("fl_busy", 64'h3);     chk(64'(rbusy));
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd4;
        wen = 1'b1; waddr = 5'd10; wdata = 64'hAAAA;
        tick(); idle(); rd(5'd4, 5'd10); #1;
        push("fl_cnt0", 64'h0);     chk(64'(busy_cnt));
        push("fl_busy0", 64'h0);    chk(64'(rbusy));
        push("fl_data", 64'hAAAA);  chk(rdata[2*DW-1:DW]);

        // every non-zero register busy: count must reach 31 without wrapping
        for (int r = 1; r < (1 << AW); r++) begin
            iss_en = 1'b1; iss_rd = AW'(r);
            tick();
        end
        idle(); rd(5'd31, 5'd0); #1;
        push("all_cnt", 64'd31);    chk(64'(busy_cnt));
        push("all_busy", 64'h1);    chk(64'(rbusy));
        flush = 1'b1;
        tick(); idle();

        // asynchronous reset mid-cycle
        wen = 1'b1; waddr = 5'd12; wdata = 64'hC0FFEE;
        iss_en = 1'b1; iss_rd = 5'd13;
        tick(); idle(); rd(5'd12, 5'd13); #1;
        push("mr_data", 64'hC0FFEE); chk(rdata[DW-1:0]);
        push("mr_cnt", 64'h1);      chk(64'(busy_cnt));
        #1 rst_n = 1'b0;
        #1;
        push("ar_data", 64'h0);     chk(rdata[DW-1:0]);
        push("ar_busy", 64'h0);     chk(64'(rbusy));
        push("ar_cnt", 64'h0);      chk(64'(busy_cnt));
        tick();
        rst_n = 1'b1;
        #1;
        push("ar_data_after", 64'h0); chk(rdata[DW-1:0]);

        if (q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
